// File: rtl/jam_pkg.sv
// Shared definitions for the exhaustive job-assignment engine: FSM state
// encoding, optimisation-mode encodings and a constant-foldable clog2.
package jam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EVAL = 3'd1,
    ST_ACC  = 3'd2,
    ST_UPD  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  function automatic int jam_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << r) < value) begin
        r = r + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of a permutation of 0..N-1, plus a
// flag marking the final (fully descending) permutation.
module jam_next_perm #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N*IW-1:0] perm_i,
  output logic [N*IW-1:0] perm_o,
  output logic            is_last_o
);

  logic [IW-1:0] p_s  [N];
  logic [IW-1:0] sw_s [N];
  logic [IW-1:0] q_s  [N];
  logic          found_s;
  int            piv_s;
  int            succ_s;

  // Pivot search, swap with smallest larger suffix element, suffix reversal
  always_comb begin
    found_s = 1'b0;
    piv_s   = 0;
    succ_s  = 0;
    perm_o  = perm_i;
    for (int i = 0; i < N; i++) begin
      p_s[i] = perm_i[i*IW +: IW];
    end
    for (int i = N - 2; i >= 0; i--) begin
      if (!found_s && (p_s[i] < p_s[i+1])) begin
        found_s = 1'b1;
        piv_s   = i;
      end else begin
        found_s = found_s;
      end
    end
    // The suffix is descending, so the rightmost larger element is the smallest one
    for (int j = 0; j < N; j++) begin
      if (found_s && (j > piv_s) && (p_s[j] > p_s[piv_s])) begin
        succ_s = j;
      end else begin
        succ_s = succ_s;
      end
    end
    for (int j = 0; j < N; j++) begin
      sw_s[j] = p_s[j];
    end
    sw_s[piv_s]  = p_s[succ_s];
    sw_s[succ_s] = p_s[piv_s];
    for (int j = 0; j < N; j++) begin
      if (j > piv_s) begin
        q_s[j] = sw_s[N + piv_s - j];
      end else begin
        q_s[j] = sw_s[j];
      end
    end
    if (found_s) begin
      for (int j = 0; j < N; j++) begin
        perm_o[j*IW +: IW] = q_s[j];
      end
    end else begin
      perm_o = perm_i;
    end
    is_last_o = !found_s;
  end

endmodule

// File: rtl/jam_param.sv
// START-triggered exhaustive N-worker/N-job assignment engine: walks all N!
// permutations in lexicographic order and keeps the min- or max-cost result.
module jam_param
  import jam_pkg::*;
#(
  parameter  int N   = 8,
  parameter  int CW  = 7,
  parameter  int MCW = 16,
  localparam int IW  = (jam_clog2(N) > 1) ? jam_clog2(N) : 1,
  localparam int SW  = CW + jam_clog2(N + 1)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            START,
  input  logic            MODE,
  output logic            BUSY,
  output logic [IW-1:0]   W,
  output logic [IW-1:0]   J,
  input  logic [CW-1:0]   COST,
  output logic [SW-1:0]   BEST_COST,
  output logic [MCW-1:0]  MATCH_COUNT,
  output logic [N*IW-1:0] BEST_PERM,
  output logic            VALID
);

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic            first_q, first_d;
  logic [IW-1:0]   k_q, k_d;
  logic [N*IW-1:0] perm_q, perm_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [IW-1:0]   w_q, w_d;
  logic [IW-1:0]   j_q, j_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [SW-1:0]   best_cost_q, best_cost_d;
  logic [MCW-1:0]  match_q, match_d;
  logic [N*IW-1:0] best_perm_q, best_perm_d;

  logic [N*IW-1:0] ident_s;
  logic [N*IW-1:0] next_perm_s;
  logic            is_last_s;
  logic            better_s;

  jam_next_perm #(
    .N  (N),
    .IW (IW)
  ) u_next_perm (
    .perm_i    (perm_q),
    .perm_o    (next_perm_s),
    .is_last_o (is_last_s)
  );

  // Identity permutation loaded at the start of every run
  always_comb begin
    ident_s = '0;
    for (int w = 0; w < N; w++) begin
      ident_s[w*IW +: IW] = IW'(w);
    end
  end

  // FSM, W/J issue, accumulation and result update
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    first_d     = first_q;
    k_d         = k_q;
    perm_d      = perm_q;
    sum_d       = sum_q;
    w_d         = w_q;
    j_d         = j_q;
    busy_d      = busy_q;
    valid_d     = 1'b0;
    best_cost_d = best_cost_q;
    match_d     = match_q;
    best_perm_d = best_perm_q;
    if (mode_q == MODE_MAX) begin
      better_s = (sum_q > best_cost_q);
    end else begin
      better_s = (sum_q < best_cost_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          mode_d  = MODE;
          perm_d  = ident_s;
          sum_d   = '0;
          k_d     = '0;
          w_d     = '0;
          j_d     = ident_s[IW-1:0];
          first_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_EVAL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EVAL: begin
        // COST seen in the first EVAL cycle still belongs to the previous lookup
        if (k_q != '0) begin
          sum_d = sum_q + SW'(COST);
        end else begin
          sum_d = sum_q;
        end
        if (k_q == IW'(N - 1)) begin
          w_d     = '0;
          j_d     = '0;
          state_d = ST_ACC;
        end else begin
          k_d = k_q + IW'(1);
          w_d = k_q + IW'(1);
          j_d = perm_q[IW*(int'(k_q) + 1) +: IW];
        end
      end
      ST_ACC: begin
        sum_d   = sum_q + SW'(COST);
        state_d = ST_UPD;
      end
      ST_UPD: begin
        if (first_q || better_s) begin
          best_cost_d = sum_q;
          match_d     = MCW'(1);
          best_perm_d = perm_q;
        end else if (sum_q == best_cost_q) begin
          if (match_q != {MCW{1'b1}}) begin
            match_d = match_q + MCW'(1);
          end else begin
            match_d = match_q;
          end
        end else begin
          match_d = match_q;
        end
        first_d = 1'b0;
        if (is_last_s) begin
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          perm_d  = next_perm_s;
          sum_d   = '0;
          k_d     = '0;
          w_d     = '0;
          j_d     = next_perm_s[IW-1:0];
          state_d = ST_EVAL;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_MIN;
      first_q     <= 1'b0;
      k_q         <= '0;
      perm_q      <= '0;
      sum_q       <= '0;
      w_q         <= '0;
      j_q         <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      best_cost_q <= '0;
      match_q     <= '0;
      best_perm_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      first_q     <= first_d;
      k_q         <= k_d;
      perm_q      <= perm_d;
      sum_q       <= sum_d;
      w_q         <= w_d;
      j_q         <= j_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      best_cost_q <= best_cost_d;
      match_q     <= match_d;
      best_perm_q <= best_perm_d;
    end
  end

  assign BUSY        = busy_q;
  assign VALID       = valid_q;
  assign W           = w_q;
  assign J           = j_q;
  assign BEST_COST   = best_cost_q;
  assign MATCH_COUNT = match_q;
  assign BEST_PERM   = best_perm_q;

endmodule

// File: tb/tb_jam_param.sv
// Self-checking bench for jam_param at N=4: directed tables plus random cost
// tables compared against an enumerate-all-tuples reference model.
module tb_jam_param;

  localparam int N        = 4;
  localparam int CW       = 7;
  localparam int MCW      = 16;
  localparam int IW       = 2;
  localparam int SW       = 10;
  localparam int NPERM    = 24;
  localparam int DONE_CYC = NPERM * (N + 2) + 1;
  localparam int LIMIT    = DONE_CYC + 20;

  logic            CLK   = 1'b0;
  logic            RST_N = 1'b1;
  logic            START = 1'b0;
  logic            MODE  = 1'b0;
  logic            BUSY;
  logic            VALID;
  logic [IW-1:0]   W;
  logic [IW-1:0]   J;
  logic [CW-1:0]   COST = '0;
  logic [SW-1:0]   BEST_COST;
  logic [MCW-1:0]  MATCH_COUNT;
  logic [N*IW-1:0] BEST_PERM;

  int checks = 0;
  int errors = 0;
  int tab [N][N];

  jam_param #(.N(N), .CW(CW), .MCW(MCW)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .START       (START),
    .MODE        (MODE),
    .BUSY        (BUSY),
    .W           (W),
    .J           (J),
    .COST        (COST),
    .BEST_COST   (BEST_COST),
    .MATCH_COUNT (MATCH_COUNT),
    .BEST_PERM   (BEST_PERM),
    .VALID       (VALID)
  );

  always #5 CLK = ~CLK;

  // External cost ROM with one cycle of read latency
  always @(posedge CLK) COST <= CW'(tab[W][J]);

  // Reference: scan every N-digit base-N tuple in ascending order (worker 0
  // is the most significant digit) and keep only those with distinct digits.
  task automatic ref_model(input logic mode, output int best, output int cnt,
                           output logic [N*IW-1:0] bperm);
    int  total;
    bit  first;
    total = 1;
    for (int i = 0; i < N; i++) total = total * N;
    first = 1'b1; best = 0; cnt = 0; bperm = '0;
    for (int code = 0; code < total; code++) begin
      int d [N];
      bit seen [N];
      int x;
      int s;
      bit ok;
      x = code; s = 0; ok = 1'b1;
      for (int w = 0; w < N; w++) seen[w] = 1'b0;
      for (int w = N - 1; w >= 0; w--) begin d[w] = x % N; x = x / N; end
      for (int w = 0; w < N; w++) begin
        if (seen[d[w]]) ok = 1'b0;
        seen[d[w]] = 1'b1;
      end
      if (ok) begin
        for (int w = 0; w < N; w++) s = s + tab[w][d[w]];
        if (first || (mode ? (s > best) : (s < best))) begin
          best = s; cnt = 1; first = 1'b0;
          for (int w = 0; w < N; w++) bperm[w*IW +: IW] = IW'(d[w]);
        end else if (s == best && cnt < 65535) begin
          cnt = cnt + 1;
        end
      end
    end
  endtask

  // Called at a negedge in an IDLE cycle (cycle 0); returns at the negedge of the VALID cycle
  task automatic run_dut(input logic mode, input bit noise, output int vcyc, output int busy_low);
    vcyc = -1; busy_low = 0;
    START = 1'b1; MODE = mode;
    for (int c = 1; c <= LIMIT; c++) begin
      @(negedge CLK);
      START = noise && ((c % 29) == 3);
      MODE  = noise ? 1'($urandom_range(0, 1)) : mode;
      if (!BUSY) busy_low++;
      if (VALID) begin vcyc = c; break; end
    end
    START = 1'b0;
  endtask

  task automatic fill_table(input int lo, input int hi);
    for (int w = 0; w < N; w++)
      for (int j = 0; j < N; j++) tab[w][j] = $urandom_range(hi, lo);
  endtask

  task automatic test_reset();
    #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", BUSY); end
    checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", VALID); end
    checks++; if ({W, J} !== '0) begin errors++; $display("FAIL reset_wj got W=%0d J=%0d exp 0", W, J); end
    checks++; if (BEST_COST !== '0) begin errors++; $display("FAIL reset_best_cost got %0d exp 0", BEST_COST); end
    checks++; if (MATCH_COUNT !== '0) begin errors++; $display("FAIL reset_match got %0d exp 0", MATCH_COUNT); end
    checks++; if (BEST_PERM !== '0) begin errors++; $display("FAIL reset_perm got %h exp 0", BEST_PERM); end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_identity_table();
    int vc, bl;
    for (int w = 0; w < N; w++)
      for (int j = 0; j < N; j++) tab[w][j] = (w == j) ? 0 : 5;
    run_dut(1'b0, 1'b0, vc, bl);
    checks++; if (vc !== DONE_CYC) begin errors++; $display("FAIL ident_min_valid_cycle got %0d exp %0d", vc, DONE_CYC); end
    checks++; if (bl !== 0) begin errors++; $display("FAIL ident_min_busy got %0d low cycles exp 0", bl); end
    checks++; if (BEST_COST !== SW'(0)) begin errors++; $display("FAIL ident_min_cost got %0d exp 0", BEST_COST); end
    checks++; if (MATCH_COUNT !== MCW'(1)) begin errors++; $display("FAIL ident_min_count got %0d exp 1", MATCH_COUNT); end
    checks++; if (BEST_PERM !== 8'hE4) begin errors++; $display("FAIL ident_min_perm got %h exp e4", BEST_PERM); end
    @(negedge CLK);
    checks++; if (VALID !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL valid_pulse got VALID=%0b BUSY=%0b exp 0 0", VALID, BUSY); end
    @(negedge CLK);
    run_dut(1'b1, 1'b0, vc, bl);
    checks++; if (BEST_COST !== SW'(20)) begin errors++; $display("FAIL ident_max_cost got %0d exp 20", BEST_COST); end
    checks++; if (MATCH_COUNT !== MCW'(9)) begin errors++; $display("FAIL ident_max_count got %0d exp 9", MATCH_COUNT); end
    checks++; if (BEST_PERM !== 8'hB1) begin errors++; $display("FAIL ident_max_perm got %h exp b1", BEST_PERM); end
    @(negedge CLK);
  endtask

  task automatic test_uniform();
    int vc, bl;
    int vals [2];
    vals[0] = 7; vals[1] = 0;
    for (int t = 0; t < 2; t++) begin
      for (int w = 0; w < N; w++)
        for (int j = 0; j < N; j++) tab[w][j] = vals[t];
      run_dut(t[0], 1'b0, vc, bl);
      checks++; if (BEST_COST !== SW'(4 * vals[t])) begin errors++; $display("FAIL uniform_cost val %0d got %0d exp %0d", vals[t], BEST_COST, 4 * vals[t]); end
      checks++; if (MATCH_COUNT !== MCW'(24)) begin errors++; $display("FAIL uniform_count val %0d got %0d exp 24", vals[t], MATCH_COUNT); end
      checks++; if (BEST_PERM !== 8'hE4) begin errors++; $display("FAIL uniform_perm val %0d got %h exp e4", vals[t], BEST_PERM); end
      @(negedge CLK);
    end
  endtask

  task automatic test_random();
    int vc, bl, eb, ec;
    logic [N*IW-1:0] ep;
    logic m;
    for (int r = 0; r < 6; r++) begin
      if (r[0]) fill_table(0, 2); else fill_table(0, 127);
      m = 1'($urandom_range(0, 1));
      ref_model(m, eb, ec, ep);
      run_dut(m, 1'b1, vc, bl);
      checks++; if (vc !== DONE_CYC) begin errors++; $display("FAIL rand_valid_cycle run %0d got %0d exp %0d", r, vc, DONE_CYC); end
      checks++; if (bl !== 0) begin errors++; $display("FAIL rand_busy run %0d got %0d low cycles exp 0", r, bl); end
      checks++; if (BEST_COST !== SW'(eb)) begin errors++; $display("FAIL rand_cost run %0d mode %0b got %0d exp %0d", r, m, BEST_COST, eb); end
      checks++; if (MATCH_COUNT !== MCW'(ec)) begin errors++; $display("FAIL rand_count run %0d mode %0b got %0d exp %0d", r, m, MATCH_COUNT, ec); end
      checks++; if (BEST_PERM !== ep) begin errors++; $display("FAIL rand_perm run %0d mode %0b got %h exp %h", r, m, BEST_PERM, ep); end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    int vc, bl, eb0, ec0, eb1, ec1;
    logic [N*IW-1:0] ep0, ep1;
    fill_table(0, 3);
    ref_model(1'b0, eb0, ec0, ep0);
    ref_model(1'b1, eb1, ec1, ep1);
    run_dut(1'b0, 1'b0, vc, bl);
    checks++; if (BEST_COST !== SW'(eb0) || MATCH_COUNT !== MCW'(ec0) || BEST_PERM !== ep0) begin
      errors++; $display("FAIL b2b_first got %0d/%0d/%h exp %0d/%0d/%h", BEST_COST, MATCH_COUNT, BEST_PERM, eb0, ec0, ep0); end
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL b2b_busy_fall got %0b exp 0", BUSY); end
    run_dut(1'b1, 1'b0, vc, bl);
    checks++; if (vc !== DONE_CYC) begin errors++; $display("FAIL b2b_valid_cycle got %0d exp %0d", vc, DONE_CYC); end
    checks++; if (BEST_COST !== SW'(eb1) || MATCH_COUNT !== MCW'(ec1) || BEST_PERM !== ep1) begin
      errors++; $display("FAIL b2b_second got %0d/%0d/%h exp %0d/%0d/%h", BEST_COST, MATCH_COUNT, BEST_PERM, eb1, ec1, ep1); end
    @(negedge CLK);
  endtask

  task automatic test_midrun_reset();
    int vc, bl, eb, ec, vseen, bseen;
    logic [N*IW-1:0] ep;
    fill_table(0, 127);
    ref_model(1'b1, eb, ec, ep);
    START = 1'b1; MODE = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (60) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    checks++; if ({BUSY, VALID, W, J} !== '0) begin errors++; $display("FAIL midreset_ctrl got BUSY=%0b VALID=%0b W=%0d J=%0d exp 0", BUSY, VALID, W, J); end
    checks++; if (BEST_COST !== '0 || MATCH_COUNT !== '0 || BEST_PERM !== '0) begin
      errors++; $display("FAIL midreset_results got %0d/%0d/%h exp 0", BEST_COST, MATCH_COUNT, BEST_PERM); end
    RST_N = 1'b1;
    vseen = 0; bseen = 0;
    for (int c = 0; c < 2 * DONE_CYC; c++) begin
      @(negedge CLK);
      if (VALID) vseen++;
      if (BUSY) bseen++;
    end
    checks++; if (vseen !== 0 || bseen !== 0) begin errors++; $display("FAIL midreset_quiet got VALID %0d BUSY %0d cycles exp 0", vseen, bseen); end
    run_dut(1'b1, 1'b0, vc, bl);
    checks++; if (vc !== DONE_CYC) begin errors++; $display("FAIL midreset_rerun_cycle got %0d exp %0d", vc, DONE_CYC); end
    checks++; if (BEST_COST !== SW'(eb) || MATCH_COUNT !== MCW'(ec) || BEST_PERM !== ep) begin
      errors++; $display("FAIL midreset_rerun got %0d/%0d/%h exp %0d/%0d/%h", BEST_COST, MATCH_COUNT, BEST_PERM, eb, ec, ep); end
    @(negedge CLK);
  endtask

  initial begin
    for (int w = 0; w < N; w++)
      for (int j = 0; j < N; j++) tab[w][j] = 0;
    test_reset();
    test_identity_table();
    test_uniform();
    test_random();
    test_back_to_back();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
